// File: rtl/interrupt_arbiter_8_pkg.sv
// Shared definitions for the 8-input interrupt arbiter.
// Holds the FSM state encoding, the requester count and index width, and a
// rotate helper used when the ARB_ROUND_ROBIN_EN build option is enabled.
package irq_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // Rotate right so that bit s of the input lands in bit 0 of the result.
  function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] v,
                                            input logic [ID_W-1:0]  s);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int k = 0; k < N_REQ; k++) begin
      r[k] = v[(k + int'(s)) % N_REQ];
    end
    return r;
  endfunction

endpackage

// File: rtl/interrupt_arbiter_8_if.sv
// Request/grant bundle between interrupt sources and the arbiter.
// master: the requester side (drives enable, requests, ack).
// slave:  the arbiter (drives grant, group-select, cascade and busy flags).
interface interrupt_arbiter_8_if;
  import irq_arb_pkg::*;

  logic              ei_n;
  logic [N_REQ-1:0]  req_n;
  logic              ack;
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_id;
  logic              gs_n;
  logic              eo_n;
  logic              busy;

  modport master (
    output ei_n, req_n, ack,
    input  gnt_valid, gnt_id, gs_n, eo_n, busy
  );

  modport slave (
    input  ei_n, req_n, ack,
    output gnt_valid, gnt_id, gs_n, eo_n, busy
  );

endinterface

// File: rtl/interrupt_arbiter_8_pri_enc.sv
// pri_enc_8: combinational 8-input priority encoder with active-low inputs.
// Reports the highest-index asserted (low) bit and whether any bit is low.
module pri_enc_8
  import irq_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_n,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan upward so the last (highest) asserted bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!req_n[i]) begin
        idx = ID_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter_8.sv
// interrupt_arbiter_8: 8-way interrupt arbiter with IDLE/GRANT/RELEASE FSM.
// Default build uses fixed priority (bit 7 highest). Defining the macro
// ARB_ROUND_ROBIN_EN adds a rotating priority pointer that moves to just
// below the last winner after each grant. All outputs are registered.
// DELAY is a simulation-only output delay; it has no effect on the cycle
// behaviour and is not modelled in this synthesizable description.
module interrupt_arbiter_8
  import irq_arb_pkg::*;
#(
  parameter int DELAY = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  interrupt_arbiter_8_if.slave bus
);

  if (DELAY < 0) begin : g_bad_delay
    $error("interrupt_arbiter_8: DELAY must be non-negative");
  end

  logic [1:0]       state_q,     state_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]  gnt_id_q,    gnt_id_d;
  logic             gs_n_q,      gs_n_d;
  logic             eo_n_q,      eo_n_d;
  logic             busy_q,      busy_d;

  logic [N_REQ-1:0] enc_req_n;
  logic [ID_W-1:0]  enc_idx;
  logic             enc_any;
  logic [ID_W-1:0]  winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  rot_amt;

  // Rotate so the pointer position appears at bit 7, then undo the rotation.
  always_comb begin
    rot_amt   = ptr_q + 3'd1;
    enc_req_n = rotr(bus.req_n, rot_amt);
    winner    = enc_idx + rot_amt;
  end
`else
  // Fixed priority: encoder sees the raw request lines.
  always_comb begin
    enc_req_n = bus.req_n;
    winner    = enc_idx;
  end
`endif

  pri_enc_8 u_pri_enc (
    .req_n (enc_req_n),
    .idx   (enc_idx),
    .any   (enc_any)
  );

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    gs_n_d      = gs_n_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        gs_n_d      = 1'b1;
        if (!bus.ei_n && enc_any) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_id_d    = winner;
          gs_n_d      = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d       = winner - 3'd1;
`endif
        end
      end
      GRANT: begin
        if (bus.ack) begin
          state_d     = RELEASE;
          gnt_valid_d = 1'b0;
          gs_n_d      = 1'b1;
        end
      end
      RELEASE: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        gs_n_d      = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        gs_n_d      = 1'b1;
      end
    endcase
    eo_n_d = !((state_d == IDLE) && !bus.ei_n && (bus.req_n == 8'hFF));
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      gs_n_q      <= 1'b1;
      eo_n_q      <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= 3'd7;
`endif
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      gs_n_q      <= gs_n_d;
      eo_n_q      <= eo_n_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gs_n      = gs_n_q;
  assign bus.eo_n      = eo_n_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_interrupt_arbiter_8.sv
// Testbench for interrupt_arbiter_8: a cycle-by-cycle vector table plus
// hand-written sequences for rotation order and grant-to-grant spacing.
// Expected grant order adapts to the ARB_ROUND_ROBIN_EN build option.
module tb_interrupt_arbiter_8;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  interrupt_arbiter_8_if arb_if ();

  interrupt_arbiter_8 #(.DELAY(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ei_n;
    logic [7:0] req_n;
    logic       ack;
    logic       v;
    logic [2:0] id;
    logic       gs_n;
    logic       eo_n;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                              input logic a, input logic v, input logic [2:0] id,
                              input logic gs, input logic eo, input logic b);
    vec_t t;
    t.rst = r; t.ei_n = e; t.req_n = q; t.ack = a;
    t.v = v; t.id = id; t.gs_n = gs; t.eo_n = eo; t.busy = b;
    return t;
  endfunction

  // Drive inputs, advance one rising edge and settle just after it.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q,
                               input logic a);
    rst          = r;
    arb_if.ei_n  = e;
    arb_if.req_n = q;
    arb_if.ack   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t exp);
    logic [6:0] act, req;
    act = {arb_if.gnt_valid, arb_if.gnt_id, arb_if.gs_n, arb_if.eo_n, arb_if.busy};
    req = {exp.v, exp.id, exp.gs_n, exp.eo_n, exp.busy};
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: {valid,id,gs_n,eo_n,busy} got %b_%0d_%b_%b_%b expected %b_%0d_%b_%b_%b",
               name, act[6], act[5:3], act[2], act[1], act[0],
               req[6], req[5:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int   cyc;
    int   expId;
    vec_t exp;
    testsRun    = 0;
    testsFailed = 0;
    rst          = 1'b1;
    arb_if.ei_n  = 1'b0;
    arb_if.req_n = 8'h00;
    arb_if.ack   = 1'b0;
    #1;

    //             rst  ei   req_n         ack  v    id  gs   eo   busy
    // reset held with all requests pending, first grant right after
    vecs.push_back(mk(1, 0, 8'h00,        0,   0, 0,  1,   1,   0));
    vecs.push_back(mk(1, 0, 8'h00,        0,   0, 0,  1,   1,   0));
    vecs.push_back(mk(0, 0, 8'h00,        0,   1, 7,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'h00,        1,   0, 7,  1,   1,   1));
    vecs.push_back(mk(0, 0, 8'hFF,        0,   0, 7,  1,   0,   0));
    // requests 5 and 3: 5 held four cycles, 5 withdraws on ack, then 3
    vecs.push_back(mk(0, 0, 8'b1101_0111, 0,   1, 5,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'b1101_0111, 0,   1, 5,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'b1101_0111, 0,   1, 5,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'b1101_0111, 0,   1, 5,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'b1111_0111, 1,   0, 5,  1,   1,   1));
    vecs.push_back(mk(0, 0, 8'b1111_0111, 1,   0, 5,  1,   1,   0));
    vecs.push_back(mk(0, 0, 8'b1111_0111, 0,   1, 3,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'hFF,        1,   0, 3,  1,   1,   1));
    vecs.push_back(mk(0, 1, 8'hFF,        0,   0, 3,  1,   1,   0));
    // enable gating: no grant while ei_n=1, grant holds through ei_n/req changes
    vecs.push_back(mk(1, 1, 8'h00,        0,   0, 0,  1,   1,   0));
    vecs.push_back(mk(0, 1, 8'h00,        0,   0, 0,  1,   1,   0));
    vecs.push_back(mk(0, 1, 8'h00,        0,   0, 0,  1,   1,   0));
    vecs.push_back(mk(0, 0, 8'h00,        0,   1, 7,  0,   1,   1));
    vecs.push_back(mk(0, 1, 8'h00,        0,   1, 7,  0,   1,   1));
    vecs.push_back(mk(0, 1, 8'hFF,        0,   1, 7,  0,   1,   1));
    vecs.push_back(mk(0, 1, 8'hFF,        1,   0, 7,  1,   1,   1));
    // cascade: idle with no requests drives eo_n low; ack in IDLE ignored
    vecs.push_back(mk(0, 0, 8'hFF,        1,   0, 7,  1,   0,   0));
    vecs.push_back(mk(0, 0, 8'hFF,        1,   0, 7,  1,   0,   0));
    vecs.push_back(mk(0, 0, 8'hFE,        0,   1, 0,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'hFF,        1,   0, 0,  1,   1,   1));
    vecs.push_back(mk(0, 0, 8'hFF,        0,   0, 0,  1,   0,   0));
    // reset in the middle of a grant to requester 4
    vecs.push_back(mk(0, 0, 8'b1110_1111, 0,   1, 4,  0,   1,   1));
    vecs.push_back(mk(0, 0, 8'b1110_1111, 0,   1, 4,  0,   1,   1));
    vecs.push_back(mk(1, 0, 8'b1110_1111, 0,   0, 0,  1,   1,   0));
    vecs.push_back(mk(0, 0, 8'hFF,        1,   0, 0,  1,   0,   0));
    vecs.push_back(mk(0, 0, 8'hFF,        1,   0, 0,  1,   0,   0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].ei_n, vecs[i].req_n, vecs[i].ack);
      checkOutput($sformatf("row%0d", i), vecs[i]);
    end

    // Rotation order with every request pending and an ack in each grant.
    applyStimulus(1, 0, 8'h00, 0);
    for (int k = 0; k < 9; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expId = (15 - k) % 8;
`else
      expId = 7;
`endif
      applyStimulus(0, 0, 8'h00, 0);
      exp = mk(0, 0, 8'h00, 0, 1, 3'(expId), 0, 1, 1);
      checkOutput($sformatf("order_grant%0d", k), exp);
      applyStimulus(0, 0, 8'h00, 1);
      exp = mk(0, 0, 8'h00, 1, 0, 3'(expId), 1, 1, 1);
      checkOutput($sformatf("order_release%0d", k), exp);
      applyStimulus(0, 0, 8'h00, 0);
      exp = mk(0, 0, 8'h00, 0, 0, 3'(expId), 1, 1, 0);
      checkOutput($sformatf("order_idle%0d", k), exp);
    end

    // Grant-to-grant spacing measured from the ack edge, bounded waits.
    applyStimulus(1, 0, 8'h00, 0);
    rst = 1'b0;
    cyc = 0;
    while (!arb_if.gnt_valid && cyc < 10) begin
      applyStimulus(0, 0, 8'h00, 0);
      cyc++;
    end
    checkVal("first_grant_latency", cyc, 1);
    applyStimulus(0, 0, 8'h00, 1);
    cyc = 1;
    while (!arb_if.gnt_valid && cyc < 10) begin
      applyStimulus(0, 0, 8'h00, 0);
      cyc++;
    end
    checkVal("grant_spacing", cyc, 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
